// File: rtl/mem_stage_lsu_if.sv
// Data-memory request bus: single outstanding req/ack transaction.
// req is held with stable addr/be/we/wdata until the one-cycle ack; rdata is valid in the ack cycle.
interface mem_stage_lsu_if #(parameter int WIDTH = 32) ();
   logic             dmem_req;
   logic             dmem_we;
   logic [WIDTH-1:0] dmem_addr;
   logic [3:0]       dmem_be;
   logic [WIDTH-1:0] dmem_wdata;
   logic             dmem_ack;
   logic [WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues data-memory accesses, steers byte lanes,
// extends loads, stalls the front end while waiting and owns the MEM->WB register.
module mem_stage_lsu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ALUResultM,
   input  logic [WIDTH-1:0] WriteDataM,
   input  logic [WIDTH-1:0] PCPlus4M,
   input  logic [4:0]       RdM,
   input  logic             RegWriteM,
   input  logic             ResultSrcM,
   input  logic             WD3SrcM,
   input  logic [3:0]       AddrModeM,
   mem_stage_lsu_if.master  dmem,
   output logic             stall_o,
   output logic             misalign_o,
   output logic [WIDTH-1:0] ALUResultW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic [WIDTH-1:0] PCPlus4W,
   output logic [4:0]       RdW,
   output logic             RegWriteW,
   output logic             ResultSrcW,
   output logic             WD3SrcW,
   output logic             dbg_state_o
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   // Access size: 0 = byte, 1 = half, 2 = word.
   function automatic logic [1:0] size_of(input logic [3:0] mode);
      case (mode)
         4'b0000, 4'b0100, 4'b0011: size_of = 2'd0;
         4'b0001, 4'b0101, 4'b0110: size_of = 2'd1;
         default:                   size_of = 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    be_of = 4'b0001 << a;
         2'd1:    be_of = a[1] ? 4'b1100 : 4'b0011;
         default: be_of = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'd0:    wdata_of = {4{wd[7:0]}};
         2'd1:    wdata_of = {2{wd[15:0]}};
         default: wdata_of = wd;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [3:0] mode, input logic [1:0] a,
                                           input logic [31:0] rdata);
      logic [31:0] sh;
      logic [15:0] hv;
      sh = rdata >> {a, 3'b000};
      hv = a[1] ? rdata[31:16] : rdata[15:0];
      case (mode)
         4'b0000: extract = {{24{sh[7]}}, sh[7:0]};
         4'b0100: extract = {24'h0, sh[7:0]};
         4'b0001: extract = {{16{hv[15]}}, hv};
         4'b0101: extract = {16'h0, hv};
         4'b0010: extract = rdata;
         default: extract = '0;
      endcase
   endfunction

   state_t      state_q;
   logic [31:0] h_alu_q, h_wdata_q, h_pc_q;
   logic [4:0]  h_rd_q;
   logic [3:0]  h_mode_q, h_be_q;
   logic        h_we_q, h_rw_q, h_rs_q, h_wd3_q;

   logic [1:0]  a_m, size_m;
   logic        access_m, mis_m, issue_m, we_m, in_wait;
   logic [3:0]  be_m;
   logic [31:0] wdata_m;

   assign a_m      = ALUResultM[1:0];
   assign size_m   = size_of(AddrModeM);
   assign access_m = ~AddrModeM[3];
   assign mis_m    = access_m & (((size_m == 2'd1) & a_m[0]) | ((size_m == 2'd2) & (a_m != 2'b00)));
   assign we_m     = (AddrModeM == 4'b0011) | (AddrModeM == 4'b0110) | (AddrModeM == 4'b0111);
   assign be_m     = be_of(size_m, a_m);
   assign wdata_m  = wdata_of(size_m, WriteDataM);
   assign in_wait  = (state_q == S_WAIT);
   assign issue_m  = ~in_wait & access_m & ~mis_m;

   // While waiting the bus comes only from the holding registers, so it stays stable until ack.
   assign dmem.dmem_req   = rst_n & (issue_m | in_wait);
   assign dmem.dmem_addr  = in_wait ? {h_alu_q[31:2], 2'b00} : {ALUResultM[31:2], 2'b00};
   assign dmem.dmem_be    = in_wait ? h_be_q : be_m;
   assign dmem.dmem_we    = in_wait ? h_we_q : we_m;
   assign dmem.dmem_wdata = in_wait ? h_wdata_q : wdata_m;

   assign stall_o     = rst_n & (issue_m | in_wait) & ~dmem.dmem_ack;
   assign misalign_o  = rst_n & ~in_wait & mis_m;
   assign dbg_state_o = in_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         h_alu_q    <= '0;
         h_wdata_q  <= '0;
         h_pc_q     <= '0;
         h_rd_q     <= '0;
         h_mode_q   <= '0;
         h_be_q     <= '0;
         h_we_q     <= 1'b0;
         h_rw_q     <= 1'b0;
         h_rs_q     <= 1'b0;
         h_wd3_q    <= 1'b0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 1'b0;
         WD3SrcW    <= 1'b0;
      end else begin
         // Bubble by default; the branches below overwrite it when something retires.
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 1'b0;
         WD3SrcW    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (issue_m && !dmem.dmem_ack) begin
                  state_q   <= S_WAIT;
                  h_alu_q   <= ALUResultM;
                  h_wdata_q <= wdata_m;
                  h_pc_q    <= PCPlus4M;
                  h_rd_q    <= RdM;
                  h_mode_q  <= AddrModeM;
                  h_be_q    <= be_m;
                  h_we_q    <= we_m;
                  h_rw_q    <= RegWriteM;
                  h_rs_q    <= ResultSrcM;
                  h_wd3_q   <= WD3SrcM;
               end else begin
                  ALUResultW <= ALUResultM;
                  PCPlus4W   <= PCPlus4M;
                  RdW        <= RdM;
                  RegWriteW  <= RegWriteM & ~mis_m;
                  ResultSrcW <= ResultSrcM;
                  WD3SrcW    <= WD3SrcM;
                  if (issue_m && !we_m)
                     ReadDataW <= extract(AddrModeM, a_m, dmem.dmem_rdata);
               end
            end
            S_WAIT: begin
               if (dmem.dmem_ack) begin
                  state_q    <= S_IDLE;
                  ALUResultW <= h_alu_q;
                  PCPlus4W   <= h_pc_q;
                  RdW        <= h_rd_q;
                  RegWriteW  <= h_rw_q;
                  ResultSrcW <= h_rs_q;
                  WD3SrcW    <= h_wd3_q;
                  ReadDataW  <= h_we_q ? '0 : extract(h_mode_q, h_alu_q[1:0], dmem.dmem_rdata);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: responds to the data-memory bus with chosen ack
// latencies and checks bus fields and the WB register against bench-computed values.
module tb_mem_stage_lsu;

   logic        clk, rst_n;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, ResultSrcM, WD3SrcM;
   logic [3:0]  AddrModeM;
   logic        stall_o, misalign_o, dbg_state_o;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;
   logic        RegWriteW, ResultSrcW, WD3SrcW;

   mem_stage_lsu_if #(.WIDTH(32)) bus ();

   mem_stage_lsu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .WD3SrcM(WD3SrcM),
      .AddrModeM(AddrModeM), .dmem(bus.master),
      .stall_o(stall_o), .misalign_o(misalign_o),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .WD3SrcW(WD3SrcW),
      .dbg_state_o(dbg_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   logic [3:0]  r_mode;
   logic [1:0]  r_a;
   logic [31:0] r_word, r_addr;
   int          r_lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] mode, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input logic ack,
                        input logic [31:0] rdata);
      AddrModeM      = mode;
      ALUResultM     = addr;
      WriteDataM     = wd;
      RdM            = rd;
      RegWriteM      = rw;
      ResultSrcM     = 1'b0;
      WD3SrcM        = 1'b0;
      PCPlus4M       = addr + 32'h100;
      bus.dmem_ack   = ack;
      bus.dmem_rdata = rdata;
   endtask

   task automatic nop(input logic ack);
      drive(4'b1000, 32'hDEAD_BEE0, 32'h0, 5'd0, 1'b0, ack, bus.dmem_rdata);
   endtask

   // Reference load extension, written with shifts and masks.
   function automatic logic [31:0] ld_model(input logic [3:0] mode, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
      case (mode)
         4'b0000: ld_model = b[7]  ? (b | 32'hFFFF_FF00) : b;
         4'b0100: ld_model = b;
         4'b0001: ld_model = h[15] ? (h | 32'hFFFF_0000) : h;
         4'b0101: ld_model = h;
         default: ld_model = w;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;
      drive(4'b1000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      chk("rst_req", bus.dmem_req, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_rdw", RdW, 0);
      chk("rst_aluw", ALUResultW, 0);
      chk("rst_state", dbg_state_o, 0);
      rst_n = 1'b1;

      // No access passes straight to WB; an ack with no request is ignored.
      @(negedge clk);
      drive(4'b1000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b1, 32'hFFFF_FFFF);
      exp_q.push_back(32'h0);
      #1 chk("na_req", bus.dmem_req, 0);
      chk("na_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("na_rdw", RdW, 5);
      chk("na_aluw", ALUResultW, 32'h1234);
      chk("na_rww", RegWriteW, 1);
      chk("na_rdata", ReadDataW, exp_q.pop_front());
      chk("na_state", dbg_state_o, 0);

      // LB zero-wait.
      @(negedge clk);
      drive(4'b0000, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 32'h80FF_1122);
      exp_q.push_back(32'hFFFF_FF80);
      #1 chk("lb_req", bus.dmem_req, 1);
      chk("lb_addr", bus.dmem_addr, 32'h100);
      chk("lb_be", bus.dmem_be, 4'b1000);
      chk("lb_we", bus.dmem_we, 0);
      chk("lb_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("lb_rdata", ReadDataW, exp_q.pop_front());
      chk("lb_rdw", RdW, 7);

      // LHU with ack on the third cycle.
      @(negedge clk);
      drive(4'b0101, 32'h202, 32'h0, 5'd9, 1'b1, 1'b0, 32'hBEEF_0000);
      exp_q.push_back(32'h0000_BEEF);
      #1 chk("lhu_addr0", bus.dmem_addr, 32'h200);
      chk("lhu_be", bus.dmem_be, 4'b1100);
      chk("lhu_stall0", stall_o, 1);
      @(posedge clk); #1;
      chk("lhu_state", dbg_state_o, 1);
      chk("lhu_bub1_rw", RegWriteW, 0);
      chk("lhu_bub1_rd", RdW, 0);
      @(negedge clk);
      nop(1'b0);
      #1 chk("lhu_addr1", bus.dmem_addr, 32'h200);
      chk("lhu_req1", bus.dmem_req, 1);
      chk("lhu_stall1", stall_o, 1);
      @(posedge clk); #1;
      chk("lhu_bub2_rw", RegWriteW, 0);
      @(negedge clk);
      nop(1'b1);
      #1 chk("lhu_addr2", bus.dmem_addr, 32'h200);
      chk("lhu_stall2", stall_o, 0);
      @(posedge clk); #1;
      chk("lhu_rdata", ReadDataW, exp_q.pop_front());
      chk("lhu_rdw", RdW, 9);
      chk("lhu_rww", RegWriteW, 1);
      chk("lhu_aluw", ALUResultW, 32'h202);
      chk("lhu_idle", dbg_state_o, 0);

      // Stores, zero-wait.
      @(negedge clk);
      drive(4'b0011, 32'h11, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b1, 32'h0);
      #1 chk("sb_be", bus.dmem_be, 4'b0010);
      chk("sb_wdata", bus.dmem_wdata, 32'hDDDD_DDDD);
      chk("sb_we", bus.dmem_we, 1);
      chk("sb_addr", bus.dmem_addr, 32'h10);
      @(negedge clk);
      drive(4'b0110, 32'h12, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b1, 32'h0);
      #1 chk("sh_be", bus.dmem_be, 4'b1100);
      chk("sh_wdata", bus.dmem_wdata, 32'hCCDD_CCDD);
      @(negedge clk);
      drive(4'b0111, 32'h10, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b1, 32'h0);
      #1 chk("sw_be", bus.dmem_be, 4'b1111);
      chk("sw_we", bus.dmem_we, 1);
      chk("sw_wdata", bus.dmem_wdata, 32'hAABB_CCDD);
      @(posedge clk); #1;
      chk("sw_rww", RegWriteW, 0);

      // Misaligned LW.
      @(negedge clk);
      drive(4'b0010, 32'h6, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0);
      #1 chk("mis_req", bus.dmem_req, 0);
      chk("mis_pulse", misalign_o, 1);
      chk("mis_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("mis_rww", RegWriteW, 0);
      @(negedge clk);
      nop(1'b0);
      #1 chk("mis_end", misalign_o, 0);

      // Random aligned loads with 0..2 wait cycles.
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 4))
            0:       r_mode = 4'b0000;
            1:       r_mode = 4'b0001;
            2:       r_mode = 4'b0010;
            3:       r_mode = 4'b0100;
            default: r_mode = 4'b0101;
         endcase
         r_a = 2'($urandom_range(0, 3));
         if (r_mode == 4'b0001 || r_mode == 4'b0101) r_a[0] = 1'b0;
         if (r_mode == 4'b0010) r_a = 2'b00;
         r_word = $urandom;
         r_addr = ($urandom & 32'h0000_FFFC) | {30'h0, r_a};
         r_lat  = $urandom_range(0, 2);
         exp_q.push_back(ld_model(r_mode, r_a, r_word));
         @(negedge clk);
         drive(r_mode, r_addr, 32'h0, 5'(i + 10), 1'b1, r_lat == 0, r_word);
         #1 chk("rnd_addr", bus.dmem_addr, r_addr & 32'hFFFF_FFFC);
         for (int k = 1; k <= r_lat; k++) begin
            @(negedge clk);
            nop(k == r_lat);
            #1 chk("rnd_hold", bus.dmem_addr, r_addr & 32'hFFFF_FFFC);
         end
         @(posedge clk); #1;
         chk("rnd_rdata", ReadDataW, exp_q.pop_front());
         chk("rnd_rdw", RdW, 32'(i + 10));
         @(negedge clk);
         nop(1'b0);
      end

      // Reset while waiting abandons the access.
      @(negedge clk);
      drive(4'b0010, 32'h80, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      chk("rw_state", dbg_state_o, 1);
      @(negedge clk);
      nop(1'b0);
      #2 rst_n = 1'b0;
      #1 chk("rw_req", bus.dmem_req, 0);
      chk("rw_stall", stall_o, 0);
      chk("rw_state0", dbg_state_o, 0);
      chk("rw_rdw", RdW, 0);
      chk("rw_rdata", ReadDataW, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0010, 32'h40, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'h1234_5678);
      #1 chk("lw_addr", bus.dmem_addr, 32'h40);
      chk("lw_be", bus.dmem_be, 4'b1111);
      chk("lw_stall", stall_o, 1);
      @(negedge clk);
      nop(1'b1);
      bus.dmem_rdata = 32'h1234_5678;
      #1 chk("lw_addr1", bus.dmem_addr, 32'h40);
      @(posedge clk); #1;
      chk("lw_rdata", ReadDataW, exp_q.pop_front());
      chk("lw_rdw", RdW, 6);
      chk("lw_rww", RegWriteW, 1);
      @(negedge clk);
      nop(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
